// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// State encoding, R/W bit values and the default SCL divider.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP,
        DONE
    } state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int DEFAULT_CLK_DIV = 4;

    function automatic logic [7:0] addr_byte(
        input logic [6:0] addr,
        input logic       is_write
    );
        return {addr, is_write ? WRITE : READ};
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period divider: tick marks the last clk of each SCL quarter.
// Held at zero while not running so every transfer starts phase-aligned.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: address phase plus one read or write byte.
// Open-drain outputs are decoded from state and quarter index.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       write,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       busy,
    output logic       ack_err,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] q;
    logic [2:0] bit_cnt;
    logic [7:0] tx;
    logic [6:0] rx;
    logic [7:0] wdata_q;
    logic       rw;
    logic       run;
    logic       tick;
    logic       bit_end;
    logic       sample;
    logic       scl_bit;

    assign run     = (state != IDLE) && (state != DONE);
    assign bit_end = tick && (q == 2'd3);
    assign sample  = tick && (q == 2'd1);
    assign scl_bit = (q == 2'd1) || (q == 2'd2);
    assign busy    = (state != IDLE);

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        scl_o    = 1'b1;
        sda_o    = 1'b1;
        ready    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = START;
            end
            START: begin
                sda_o = (q == 2'd0);
                scl_o = (q < 2'd2);
                if (bit_end) state_nx = ADDR;
            end
            ADDR: begin
                sda_o = tx[7];
                scl_o = scl_bit;
                if (bit_end && bit_cnt == 3'd7) state_nx = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_o = scl_bit;
                if (bit_end) state_nx = ack_err ? STOP : DATA;
            end
            DATA: begin
                sda_o = tx[7];
                scl_o = scl_bit;
                if (bit_end && bit_cnt == 3'd7) state_nx = DATA_ACK;
            end
            DATA_ACK: begin
                // Released SDA: slave ACK slot on write, master NACK on read.
                scl_o = scl_bit;
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                sda_o = q[1];
                scl_o = (q != 2'd0);
                if (bit_end) state_nx = DONE;
            end
            DONE: begin
                ready    = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            wdata_q <= '0;
            rw      <= WRITE;
            rdata   <= '0;
            ack_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                q       <= '0;
                bit_cnt <= '0;
                if (start) begin
                    rw      <= write ? WRITE : READ;
                    tx      <= addr_byte(dev_addr, write);
                    wdata_q <= wdata;
                    ack_err <= 1'b0;
                end
            end else if (tick) begin
                q <= q + 2'd1;
            end

            if (sample) begin
                if (state == ADDR_ACK && sda_i) begin
                    ack_err <= 1'b1;
                end
                if (state == DATA_ACK && rw == WRITE && sda_i) begin
                    ack_err <= 1'b1;
                end
                if (state == DATA && rw == READ) begin
                    rx <= {rx[5:0], sda_i};
                    if (bit_cnt == 3'd7) rdata <= {rx, sda_i};
                end
            end

            if (bit_end) begin
                if (state == ADDR || state == DATA) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    tx      <= {tx[6:0], 1'b1};
                end
                // A read keeps SDA released through the data byte.
                if (state == ADDR_ACK) begin
                    tx <= (rw == WRITE) ? wdata_q : 8'hFF;
                end
            end
        end
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCL quarter-period; legal range 2..255.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  command request; sampled only in IDLE.
REQ-005 SHALL have port write  in  1  1 = write one byte, 0 = read one byte.
REQ-006 SHALL have port dev_addr  in  7  target I2C device address.
REQ-007 SHALL have port wdata  in  8  byte to transmit on a write.
REQ-008 SHALL have port rdata  out  8  byte received on a read; holds until the next read completes.
REQ-009 SHALL have port ready  out  1  single-cycle pulse on command completion, success or error.
REQ-010 SHALL have port busy  out  1  high from the cycle after start is accepted until the ready cycle, inclusive.
REQ-011 SHALL have port ack_err  out  1  NACK seen in the last command; valid with ready, held until the next accept.
REQ-012 SHALL have port scl_o  out  1  open-drain SCL; 1 = release, 0 = drive low.
REQ-013 SHALL have port sda_o  out  1  open-drain SDA; 1 = release, 0 = drive low.
REQ-014 SHALL have port sda_i  in  1  sampled SDA line level.

Function
REQ-015 SHALL use states IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
REQ-016 SHALL divide every bit period into 4 quarters (q0..q3), each CLK_DIV clk cycles long, timed by a tick at the last cycle of each quarter.
REQ-017 SHALL, in IDLE with start=1, latch write, dev_addr and wdata, clear ack_err, and enter START on the next edge.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL drive START as SDA released in q0, SDA low from q1, SCL low from q2.
REQ-020 SHALL send in ADDR the byte {dev_addr, ~write}, MSB first; R/W bit = 1 for read.
REQ-021 SHALL, for each data/ack bit, change SDA in q0 with SCL low, hold SCL released in q1–q2, drive SCL low in q3, and sample sda_i on the q1 tick.
REQ-022 SHALL, in ADDR_ACK, release SDA; sda_i=1 sets ack_err and goes to STOP, otherwise to DATA.
REQ-023 SHALL, on a write, shift out wdata MSB first in DATA; DATA_ACK samples the slave ACK, and sda_i=1 sets ack_err.
REQ-024 SHALL, on a read, release SDA in DATA, shift sampled bits MSB first into rdata, then send NACK (SDA released) in DATA_ACK.
REQ-025 SHALL drive STOP as SDA low in q0–q1, SCL released from q1, SDA released from q2; q3 idles, then DONE.
REQ-026 SHALL assert ready in DONE for exactly one cycle, then return to IDLE.
REQ-027 SHALL produce a successful-command latency of 20 bit periods (80*CLK_DIV cycles) from the accept edge to ready; 320 cycles at CLK_DIV=4.
REQ-028 SHALL produce an address-NACK command latency of 11 bit periods (44*CLK_DIV cycles).
REQ-029 SHALL accept start in the IDLE cycle directly after ready (back-to-back).
REQ-030 SHALL NOT support clock stretching or arbitration; SCL is never sampled.

Reset
REQ-031 SHALL, with reset=0 at any time including mid-transfer, immediately force state=IDLE, scl_o=1, sda_o=1, busy=0, ready=0, ack_err=0, rdata=8'h00, and clear the divider and bit counters.
REQ-032 SHALL accept a command on the first edge with reset=1 and start=1.

Structure
REQ-033 SHALL take the state enum, the R/W bit encoding constants (READ=1, WRITE=0) and the default CLK_DIV from shared package i2c_pkg.
REQ-034 SHALL place the quarter-period tick counter in sub-module i2c_tick_gen (inputs clk, reset, run; output tick).

Verification
REQ-035 SHALL cover: CLK_DIV=4, write dev_addr=7'h50, wdata=8'hA5, slave ACKs both -> SDA carries 8'hA0 then 8'hA5, ready at cycle 320, ack_err=0.
REQ-036 SHALL cover: read dev_addr=7'h50, slave ACKs and returns 8'h3C -> address byte 8'hA1, master NACKs, rdata=8'h3C, ack_err=0.
REQ-037 SHALL cover: write to an absent device (sda_i stays 1) -> ack_err=1, STOP issued, ready at cycle 176.
REQ-038 SHALL cover: reset=0 during the 4th DATA bit -> scl_o=sda_o=1 and busy=0 in the same cycle; the next command completes normally.
REQ-039 SHALL cover: start held high through a transfer, then re-pulsed the cycle after ready -> exactly two commands run, and none is accepted while busy.
